// File: rtl/spi_register_pkg.sv
// rtl/spi_register_pkg.sv - opcodes, fixed response bytes and router state encoding
package spi_register_pkg;

    localparam logic [7:0] OPCODE_CHIP_ID = 8'hDB;
    localparam logic [7:0] OPCODE_SPARE_0 = 8'h20;
    localparam logic [7:0] OPCODE_SPARE_1 = 8'h21;
    localparam logic [7:0] OPCODE_SPARE_2 = 8'h22;

    localparam logic [7:0] RESP_UNKNOWN = 8'h00;
    localparam logic [7:0] RESP_TIMEOUT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECTED = 2'd1,
        UNKNOWN  = 2'd2,
        TIMEOUT  = 2'd3
    } router_state_t;

endpackage

// File: rtl/spi_register_address_decoder.sv
// rtl/spi_register_address_decoder.sv - combinational opcode to table index match
module spi_register_address_decoder
    import spi_register_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter logic [NUM_ENTRIES*8-1:0] ADDRESS_TABLE =
        {OPCODE_SPARE_2, OPCODE_SPARE_1, OPCODE_SPARE_0, OPCODE_CHIP_ID},
    parameter int INDEX_WIDTH = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic [7:0]             i_opcode,
    output logic                   o_hit,
    output logic [INDEX_WIDTH-1:0] o_index
);

    // Walk from the top entry down so the lowest matching index is written last.
    always_comb begin
        o_hit   = 1'b0;
        o_index = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ADDRESS_TABLE[i*8 +: 8] == i_opcode) begin
                o_hit   = 1'b1;
                o_index = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/spi_register_router.sv
// rtl/spi_register_router.sv - routes SPI opcodes to one register sub-peripheral
module spi_register_router
    import spi_register_pkg::*;
#(
    parameter int NUM_SUBPERIPHERALS = 4,
    parameter logic [NUM_SUBPERIPHERALS*8-1:0] ADDRESS_TABLE =
        {OPCODE_SPARE_2, OPCODE_SPARE_1, OPCODE_SPARE_0, OPCODE_CHIP_ID},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [7:0]                      opcode,
    input  logic                            opcode_valid,
    input  logic [7:0]                      operand_in,
    input  logic                            operand_in_valid,
    output logic [7:0]                      operand_out,
    output logic                            operand_out_valid,
    output logic [NUM_SUBPERIPHERALS-1:0]   sub_enable,
    output logic [NUM_SUBPERIPHERALS-1:0]   sub_operand_valid,
    input  logic [NUM_SUBPERIPHERALS*8-1:0] sub_data_out,
    input  logic [NUM_SUBPERIPHERALS-1:0]   sub_data_out_valid,
    input  logic                            error_clear,
    output logic                            error_unknown_opcode,
    output logic                            error_timeout
);

    localparam int IDX_W = (NUM_SUBPERIPHERALS > 1) ? $clog2(NUM_SUBPERIPHERALS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    router_state_t                 r_state, w_state_next;
    logic [IDX_W-1:0]              r_sel, w_sel_next;
    logic [CNT_W-1:0]              r_count, w_count_next;
    logic                          r_responded, w_responded_next;
    logic [7:0]                    r_operand_out, w_operand_out_next;
    logic                          r_operand_out_valid, w_operand_out_valid_next;
    logic [NUM_SUBPERIPHERALS-1:0] r_sub_enable, w_sub_enable_next;
    logic [NUM_SUBPERIPHERALS-1:0] r_sub_operand_valid, w_sub_operand_valid_next;
    logic                          r_err_unknown, r_err_timeout;
    logic                          w_set_unknown, w_set_timeout;

    logic                          w_hit;
    logic [IDX_W-1:0]              w_hit_index;
    logic [NUM_SUBPERIPHERALS-1:0] w_hit_onehot;
    logic [7:0]                    w_sel_data;
    logic                          w_sel_valid;
    logic [CNT_W-1:0]              w_count_inc;

    spi_register_address_decoder #(
        .NUM_ENTRIES   (NUM_SUBPERIPHERALS),
        .ADDRESS_TABLE (ADDRESS_TABLE),
        .INDEX_WIDTH   (IDX_W)
    ) u_decoder (
        .i_opcode (opcode),
        .o_hit    (w_hit),
        .o_index  (w_hit_index)
    );

    always_comb begin
        w_hit_onehot = '0;
        w_sel_data   = '0;
        w_sel_valid  = 1'b0;
        for (int i = 0; i < NUM_SUBPERIPHERALS; i++) begin
            w_hit_onehot[i] = (w_hit_index == IDX_W'(i));
            if (r_sel == IDX_W'(i)) begin
                w_sel_data  = sub_data_out[i*8 +: 8];
                w_sel_valid = sub_data_out_valid[i];
            end
        end
    end

    assign w_count_inc = r_count + CNT_W'(1);

    always_comb begin
        w_state_next             = r_state;
        w_sel_next               = r_sel;
        w_count_next             = r_count;
        w_responded_next         = r_responded;
        w_operand_out_next       = '0;
        w_operand_out_valid_next = 1'b0;
        w_sub_enable_next        = '0;
        w_sub_operand_valid_next = '0;
        w_set_unknown            = 1'b0;
        w_set_timeout            = 1'b0;
        case (r_state)
            IDLE: begin
                w_count_next     = '0;
                w_responded_next = 1'b0;
                if (opcode_valid) begin
                    if (w_hit) begin
                        w_state_next      = SELECTED;
                        w_sel_next        = w_hit_index;
                        w_sub_enable_next = w_hit_onehot;
                    end else begin
                        w_state_next             = UNKNOWN;
                        w_operand_out_next       = RESP_UNKNOWN;
                        w_operand_out_valid_next = 1'b1;
                        w_set_unknown            = 1'b1;
                    end
                end
            end
            SELECTED: begin
                // The closing write strobe is still delivered as chip-select drops.
                w_sub_operand_valid_next = r_sub_enable & {NUM_SUBPERIPHERALS{operand_in_valid}};
                if (!opcode_valid) begin
                    w_state_next     = IDLE;
                    w_count_next     = '0;
                    w_responded_next = 1'b0;
                end else begin
                    w_sub_enable_next        = r_sub_enable;
                    w_operand_out_next       = w_sel_data;
                    w_operand_out_valid_next = w_sel_valid;
                    if (w_sel_valid) begin
                        w_responded_next = 1'b1;
                    end else if (!r_responded && (TIMEOUT_CYCLES != 0)) begin
                        w_count_next = w_count_inc;
                        if (w_count_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                            w_state_next             = TIMEOUT;
                            w_sub_enable_next        = '0;
                            w_sub_operand_valid_next = '0;
                            w_operand_out_next       = RESP_TIMEOUT;
                            w_operand_out_valid_next = 1'b1;
                            w_set_timeout            = 1'b1;
                        end
                    end
                end
            end
            UNKNOWN: begin
                if (!opcode_valid) begin
                    w_state_next = IDLE;
                end else begin
                    w_operand_out_next       = RESP_UNKNOWN;
                    w_operand_out_valid_next = 1'b1;
                end
            end
            TIMEOUT: begin
                if (!opcode_valid) begin
                    w_state_next     = IDLE;
                    w_count_next     = '0;
                    w_responded_next = 1'b0;
                end else begin
                    w_operand_out_next       = RESP_TIMEOUT;
                    w_operand_out_valid_next = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state             <= IDLE;
            r_sel               <= '0;
            r_count             <= '0;
            r_responded         <= 1'b0;
            r_operand_out       <= '0;
            r_operand_out_valid <= 1'b0;
            r_sub_enable        <= '0;
            r_sub_operand_valid <= '0;
            r_err_unknown       <= 1'b0;
            r_err_timeout       <= 1'b0;
        end else begin
            r_state             <= w_state_next;
            r_sel               <= w_sel_next;
            r_count             <= w_count_next;
            r_responded         <= w_responded_next;
            r_operand_out       <= w_operand_out_next;
            r_operand_out_valid <= w_operand_out_valid_next;
            r_sub_enable        <= w_sub_enable_next;
            r_sub_operand_valid <= w_sub_operand_valid_next;
            // A new error in the clear cycle must not be lost.
            r_err_unknown       <= w_set_unknown | (r_err_unknown & ~error_clear);
            r_err_timeout       <= w_set_timeout | (r_err_timeout & ~error_clear);
        end
    end

    assign operand_out          = r_operand_out;
    assign operand_out_valid    = r_operand_out_valid;
    assign sub_enable           = r_sub_enable;
    assign sub_operand_valid    = r_sub_operand_valid;
    assign error_unknown_opcode = r_err_unknown;
    assign error_timeout        = r_err_timeout;

endmodule

// File: tb/tb_spi_register_router.sv
// tb/tb_spi_register_router.sv - directed scoreboard bench for spi_register_router
module tb_spi_register_router;

    logic        clock;
    logic        reset_n;
    logic [7:0]  opcode;
    logic        opcode_valid;
    logic [7:0]  operand_in;
    logic        operand_in_valid;
    logic [7:0]  operand_out;
    logic        operand_out_valid;
    logic [3:0]  sub_enable;
    logic [3:0]  sub_operand_valid;
    logic [31:0] sub_data_out;
    logic [3:0]  sub_data_out_valid;
    logic        error_clear;
    logic        error_unknown_opcode;
    logic        error_timeout;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_out_q[$];
    logic [3:0] exp_wr_q[$];

    spi_register_router #(
        .NUM_SUBPERIPHERALS (4),
        .ADDRESS_TABLE      ({8'h22, 8'h21, 8'h20, 8'hDB}),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .opcode               (opcode),
        .opcode_valid         (opcode_valid),
        .operand_in           (operand_in),
        .operand_in_valid     (operand_in_valid),
        .operand_out          (operand_out),
        .operand_out_valid    (operand_out_valid),
        .sub_enable           (sub_enable),
        .sub_operand_valid    (sub_operand_valid),
        .sub_data_out         (sub_data_out),
        .sub_data_out_valid   (sub_data_out_valid),
        .error_clear          (error_clear),
        .error_unknown_opcode (error_unknown_opcode),
        .error_timeout        (error_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag);
        logic [7:0] exp;
        exp = 8'hxx;
        chk({tag, "_queued"}, 32'(exp_out_q.size() > 0), 32'd1);
        if (exp_out_q.size() > 0) exp = exp_out_q.pop_front();
        chk({tag, "_valid"}, 32'(operand_out_valid), 32'd1);
        chk({tag, "_data"}, 32'(operand_out), 32'(exp));
    endtask

    task automatic expect_wr(input string tag);
        logic [3:0] exp;
        exp = 4'hx;
        chk({tag, "_queued"}, 32'(exp_wr_q.size() > 0), 32'd1);
        if (exp_wr_q.size() > 0) exp = exp_wr_q.pop_front();
        chk(tag, 32'(sub_operand_valid), 32'(exp));
    endtask

    initial begin
        reset_n            = 1'b0;
        opcode             = 8'h00;
        opcode_valid       = 1'b0;
        operand_in         = 8'h00;
        operand_in_valid   = 1'b0;
        sub_data_out       = 32'h0;
        sub_data_out_valid = 4'h0;
        error_clear        = 1'b0;

        tick();
        tick();
        chk("rst_out", 32'(operand_out), 32'h0);
        chk("rst_out_valid", 32'(operand_out_valid), 32'h0);
        chk("rst_enable", 32'(sub_enable), 32'h0);
        chk("rst_wr", 32'(sub_operand_valid), 32'h0);
        chk("rst_err_unk", 32'(error_unknown_opcode), 32'h0);
        chk("rst_err_to", 32'(error_timeout), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("idle_enable", 32'(sub_enable), 32'h0);

        // chip-ID read
        opcode = 8'hDB; opcode_valid = 1'b1;
        tick();
        chk("chipid_enable", 32'(sub_enable), 32'h1);
        chk("chipid_no_early_valid", 32'(operand_out_valid), 32'h0);
        tick();
        sub_data_out[7:0] = 8'h81; sub_data_out_valid = 4'b0001;
        exp_out_q.push_back(8'h81);
        tick();
        expect_out("chipid_read");
        chk("chipid_err_unk", 32'(error_unknown_opcode), 32'h0);
        chk("chipid_err_to", 32'(error_timeout), 32'h0);
        sub_data_out_valid = 4'b0000;
        tick();
        chk("chipid_valid_drop", 32'(operand_out_valid), 32'h0);
        opcode_valid = 1'b0;
        tick();
        chk("chipid_end_enable", 32'(sub_enable), 32'h0);
        chk("chipid_end_out", 32'(operand_out), 32'h0);

        // write forwarding to sub 2
        opcode = 8'h21; opcode_valid = 1'b1;
        tick();
        chk("wr_enable", 32'(sub_enable), 32'h4);
        chk("wr_idle_strobe", 32'(sub_operand_valid), 32'h0);
        operand_in = 8'h11; operand_in_valid = 1'b1; exp_wr_q.push_back(4'b0100);
        tick();
        expect_wr("wr_byte0");
        operand_in = 8'h22; exp_wr_q.push_back(4'b0100);
        tick();
        expect_wr("wr_byte1");
        operand_in = 8'h33; exp_wr_q.push_back(4'b0100);
        tick();
        expect_wr("wr_byte2");
        operand_in_valid = 1'b0;
        tick();
        chk("wr_strobe_end", 32'(sub_operand_valid), 32'h0);
        opcode_valid = 1'b0;
        tick();

        // unknown opcode and clear
        opcode = 8'h7F; opcode_valid = 1'b1;
        exp_out_q.push_back(8'h00);
        tick();
        expect_out("unk_resp");
        chk("unk_enable", 32'(sub_enable), 32'h0);
        chk("unk_err_set", 32'(error_unknown_opcode), 32'h1);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        chk("unk_err_clear", 32'(error_unknown_opcode), 32'h0);
        chk("unk_hold_valid", 32'(operand_out_valid), 32'h1);
        opcode_valid = 1'b0;
        tick();
        chk("unk_end_valid", 32'(operand_out_valid), 32'h0);

        // timeout on sub 1
        opcode = 8'h20; opcode_valid = 1'b1;
        tick();
        for (int k = 1; k < 17; k++) begin
            chk("to_pending_err", 32'(error_timeout), 32'h0);
            chk("to_pending_enable", 32'(sub_enable), 32'h2);
            tick();
        end
        exp_out_q.push_back(8'hFF);
        expect_out("to_resp");
        chk("to_err_set", 32'(error_timeout), 32'h1);
        chk("to_enable_drop", 32'(sub_enable), 32'h0);
        opcode_valid = 1'b0; error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        chk("to_err_clear", 32'(error_timeout), 32'h0);
        chk("to_end_valid", 32'(operand_out_valid), 32'h0);

        // back-to-back transactions
        opcode = 8'hDB; opcode_valid = 1'b1;
        tick();
        chk("b2b_first_enable", 32'(sub_enable), 32'h1);
        sub_data_out[7:0] = 8'h81; sub_data_out_valid = 4'b0001;
        exp_out_q.push_back(8'h81);
        tick();
        expect_out("b2b_first_read");
        opcode_valid = 1'b0; sub_data_out_valid = 4'b0000;
        tick();
        chk("b2b_gap_enable", 32'(sub_enable), 32'h0);
        chk("b2b_gap_out", 32'(operand_out), 32'h0);
        chk("b2b_gap_valid", 32'(operand_out_valid), 32'h0);
        opcode = 8'h22; opcode_valid = 1'b1;
        tick();
        chk("b2b_second_enable", 32'(sub_enable), 32'h8);
        opcode = 8'hDB;
        tick();
        chk("b2b_no_redecode", 32'(sub_enable), 32'h8);
        opcode_valid = 1'b0;
        tick();

        // async reset while selected, strobe pending
        opcode = 8'h21; opcode_valid = 1'b1;
        tick();
        chk("ar_enable", 32'(sub_enable), 32'h4);
        operand_in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_enable_now", 32'(sub_enable), 32'h0);
        chk("ar_wr_now", 32'(sub_operand_valid), 32'h0);
        chk("ar_valid_now", 32'(operand_out_valid), 32'h0);
        opcode_valid = 1'b0;
        tick();
        operand_in_valid = 1'b0;
        chk("ar_no_leak", 32'(sub_operand_valid), 32'h0);
        reset_n = 1'b1;
        tick();

        // set wins over simultaneous clear
        opcode = 8'h7F; opcode_valid = 1'b1; error_clear = 1'b1;
        exp_out_q.push_back(8'h00);
        tick();
        error_clear = 1'b0;
        chk("setwins_err", 32'(error_unknown_opcode), 32'h1);
        expect_out("setwins_resp");
        opcode_valid = 1'b0;
        tick();
        chk("setwins_hold", 32'(error_unknown_opcode), 32'h1);

        chk("sb_out_drained", 32'(exp_out_q.size()), 32'h0);
        chk("sb_wr_drained", 32'(exp_wr_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
